// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 4x4 matrix keypad scanner:
//   - scanner FSM state encoding
//   - key codes for the non-digit keys
//   - keymap(): (row index, column index) -> 4-bit key code
//   - single_low()/low_row_idx(): decode an active-low row pattern
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Physical layout:
  //   row 0: 1 2 3 A
  //   row 1: 4 5 6 B
  //   row 2: 7 8 9 C
  //   row 3: * 0 # D
  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'd0;
    unique case ({r, c})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = KEY_D;
      default:  code = 4'd0;
    endcase
    return code;
  endfunction

  // True when exactly one row line is pulled low. No key and multiple keys in
  // the same column both come out false, so both read as "no key".
  function automatic logic single_low(input logic [3:0] rows);
    logic hit;
    hit = 1'b0;
    unique case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Index of the low row. Only meaningful when single_low() is true.
  function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (rows)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick.sv
// -----------------------------------------------------------------------------
// keypad_tick
// Free-running divider producing a one-cycle scan tick every SCAN_DIV clocks.
// Ports:
//   clock    - system clock
//   ClearAll - asynchronous active-low reset (counter returns to 0)
//   tick     - high for one cycle when the counter sits at SCAN_DIV-1
// -----------------------------------------------------------------------------
module keypad_tick #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 32
) (
  input  logic clock,
  input  logic ClearAll,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(SCAN_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // NOTE: state is always updated with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, as real hardware does.
  always_ff @(posedge clock or negedge ClearAll) begin
    if (!ClearAll) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, debounces the
// sampled rows and reports a single locked key to the calculator control unit.
// Ports:
//   clock      - system clock
//   ClearAll   - asynchronous active-low reset
//   row[3:0]   - keypad rows, active-low, asynchronous to clock
//   col[3:0]   - column drive, active-low, exactly one bit low at a time
//   keyPressed - code of the last accepted key (held after release)
//   trig       - high from key acceptance until the release is debounced
//   key_valid  - one-cycle strobe on the cycle keyPressed updates
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 20,
  parameter int CNT_W            = 32
) (
  input  logic       clock,
  input  logic       ClearAll,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] keyPressed,
  output logic       trig,
  output logic       key_valid
);

  localparam int DB_W = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [DB_W-1:0] DB_DONE = DB_W'(DEBOUNCE_SAMPLES);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic tick;

  keypad_tick #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clock    (clock),
    .ClearAll (ClearAll),
    .tick     (tick)
  );

  // Two-flop row synchronizer; idle (all-high) is the reset value so that a
  // freshly reset scanner sees "no key".
  logic [3:0] row_meta_q;
  logic [3:0] rs_q;

  state_e          state_q,   state_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [DB_W-1:0] cnt_q,     cnt_d;
  logic [3:0]      pat_q,     pat_d;
  logic [3:0]      key_q,     key_d;
  logic            trig_q,    trig_d;
  logic            valid_q,   valid_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge ClearAll) begin
    if (!ClearAll) begin
      row_meta_q <= 4'hF;
      rs_q       <= 4'hF;
      state_q    <= SCAN;
      col_idx_q  <= 2'd0;
      cnt_q      <= '0;
      pat_q      <= 4'hF;
      key_q      <= 4'd0;
      trig_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      row_meta_q <= row;
      rs_q       <= row_meta_q;
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      key_q      <= key_d;
      trig_q     <= trig_d;
      valid_q    <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Nothing moves except on tick cycles; key_valid is the
  // only signal that self-clears every cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    col_idx_d = col_idx_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    key_d     = key_q;
    trig_d    = trig_q;
    valid_d   = 1'b0;

    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (single_low(rs_q)) begin
            // Lock onto this column; col stays put while we debounce.
            pat_d   = rs_q;
            cnt_d   = DB_ONE;
            state_d = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end

        DEBOUNCE: begin
          if (rs_q == pat_q) begin
            if (cnt_q + DB_ONE == DB_DONE) begin
              key_d   = keymap(low_row_idx(pat_q), col_idx_q);
              trig_d  = 1'b1;
              valid_d = 1'b1;
              state_d = HELD;
            end else begin
              cnt_d = cnt_q + DB_ONE;
            end
          end else begin
            state_d   = SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end

        HELD: begin
          // Only the locked column is driven, so other keys are invisible here.
          if (rs_q == 4'hF) begin
            cnt_d   = DB_ONE;
            state_d = RELEASE;
          end
        end

        RELEASE: begin
          if (rs_q == 4'hF) begin
            if (cnt_q + DB_ONE == DB_DONE) begin
              trig_d    = 1'b0;
              state_d   = SCAN;
              col_idx_d = col_idx_q + 2'd1;
            end else begin
              cnt_d = cnt_q + DB_ONE;
            end
          end else begin
            // Release bounce: key is still down, no new strobe.
            state_d = HELD;
          end
        end

        default: state_d = SCAN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all straight from registers.
  // ---------------------------------------------------------------------------
  always_comb begin
    col        = ~(4'b0001 << col_idx_q);
    keyPressed = key_q;
    trig       = trig_q;
    key_valid  = valid_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SAMPLES=3.
// A behavioural keypad pulls a row low only while its key is down and the
// matching column is driven low.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV         = 4;
  localparam int DEBOUNCE_SAMPLES = 3;
  localparam int CNT_W            = 8;

  logic       clock    = 1'b0;
  logic       ClearAll = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] keyPressed;
  logic       trig;
  logic       key_valid;

  // key_down[r*4+c] = physical key at row r, column c is pressed
  logic [15:0] key_down = 16'h0000;

  int n_checks    = 0;
  int n_fail      = 0;
  int valid_count = 0;

  keypad_scanner #(
    .SCAN_DIV         (SCAN_DIV),
    .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
    .CNT_W            (CNT_W)
  ) dut (
    .clock      (clock),
    .ClearAll   (ClearAll),
    .row        (row),
    .col        (col),
    .keyPressed (keyPressed),
    .trig       (trig),
    .key_valid  (key_valid)
  );

  always #5 clock = ~clock;

  // Keypad matrix model.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Count key_valid cycles just after each active edge.
  always @(posedge clock) begin
    #1;
    if (key_valid === 1'b1) valid_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Press key (r,c) and wait (bounded) for its strobe.
  task automatic press_accept(input string tag, input int r, input int c,
                              input logic [3:0] code);
    int v0;
    bit got;
    v0  = valid_count;
    got = 1'b0;
    key_down[r*4+c] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (valid_count != v0) got = 1'b1;
    end
    check({tag, " accepted"}, 32'(got), 32'd1);
    check({tag, " code"}, 32'(keyPressed), 32'(code));
    check({tag, " trig"}, 32'(trig), 32'd1);
  endtask

  // Release everything and wait (bounded) for trig to drop.
  task automatic release_wait(input string tag, input logic [3:0] code);
    bit got;
    got = 1'b0;
    key_down = 16'h0000;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (trig == 1'b0) got = 1'b1;
    end
    check({tag, " released"}, 32'(got), 32'd1);
    check({tag, " code held"}, 32'(keyPressed), 32'(code));
  endtask

  // Full press/hold/release with an exact strobe count.
  task automatic press_release(input string tag, input int r, input int c,
                               input logic [3:0] code);
    int v0;
    v0 = valid_count;
    press_accept(tag, r, c, code);
    clocks(24);
    release_wait(tag, code);
    clocks(8);
    check({tag, " one strobe"}, 32'(valid_count - v0), 32'd1);
  endtask

  // Wait (bounded) until column 0 has just been selected.
  task automatic wait_col0_entry();
    int i;
    i = 0;
    while (col == 4'b1110 && i < 100) begin @(negedge clock); i++; end
    while (col != 4'b1110 && i < 100) begin @(negedge clock); i++; end
    check("col0 entry", 32'(i < 100), 32'd1);
  endtask

  typedef struct {
    string      name;
    int         r;
    int         c;
    logic [3:0] code;
  } key_vec_t;

  key_vec_t seq[6] = '{
    '{"key A", 0, 3, 4'd10},
    '{"key B", 1, 3, 4'd11},
    '{"key *", 3, 0, 4'd14},
    '{"key #", 3, 2, 4'd15},
    '{"key 0", 3, 1, 4'd0},
    '{"key D", 3, 3, 4'd13}
  };

  logic [3:0] col_exp[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int v0;
    bit got;
    logic [3:0] col_prev;

    // ---------------- reset values ----------------
    clocks(3);
    check("rst col", 32'(col), 32'hE);
    check("rst keyPressed", 32'(keyPressed), 32'h0);
    check("rst trig", 32'(trig), 32'h0);
    check("rst key_valid", 32'(key_valid), 32'h0);
    ClearAll = 1'b1;

    // ---------------- async reset mid-operation ----------------
    press_accept("key 6", 1, 2, 4'd6);
    @(posedge clock);
    #2 ClearAll = 1'b0;
    #1;
    check("async col", 32'(col), 32'hE);
    check("async keyPressed", 32'(keyPressed), 32'h0);
    check("async trig", 32'(trig), 32'h0);
    check("async key_valid", 32'(key_valid), 32'h0);
    key_down = 16'h0000;
    clocks(2);
    ClearAll = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rotate col %0d", k), 32'(col), 32'(col_exp[k]));
      clocks(4);
    end

    // ---------------- key 5 held 20 ticks, release timing ----------------
    v0 = valid_count;
    press_accept("key 5", 1, 1, 4'd5);
    clocks(80);
    check("key 5 hold strobes", 32'(valid_count - v0), 32'd1);
    check("key 5 hold trig", 32'(trig), 32'd1);
    key_down = 16'h0000;
    clocks(10);
    check("key 5 trig before 3 ticks", 32'(trig), 32'd1);
    clocks(4);
    check("key 5 trig after 3 ticks", 32'(trig), 32'd0);
    check("key 5 code after release", 32'(keyPressed), 32'd5);

    // ---------------- key sequence ----------------
    foreach (seq[i]) press_release(seq[i].name, seq[i].r, seq[i].c, seq[i].code);

    // ---------------- press bounce on key 7 ----------------
    wait_col0_entry();
    v0 = valid_count;
    key_down[2*4+0] = 1'b1;
    clocks(8);
    key_down = 16'h0000;
    clocks(60);
    check("bounce 7 no strobe", 32'(valid_count - v0), 32'd0);
    check("bounce 7 trig", 32'(trig), 32'd0);
    col_prev = col;
    clocks(4);
    check("bounce 7 scanning", 32'(col != col_prev), 32'd1);

    // ---------------- release bounce on key 2 ----------------
    v0 = valid_count;
    press_accept("key 2", 0, 1, 4'd2);
    clocks(12);
    key_down = 16'h0000;
    clocks(4);
    key_down[0*4+1] = 1'b1;
    clocks(40);
    check("rel bounce trig", 32'(trig), 32'd1);
    check("rel bounce strobes", 32'(valid_count - v0), 32'd1);
    release_wait("key 2", 4'd2);

    // ---------------- different-column overlap: 1 then 3 ----------------
    press_accept("key 1", 0, 0, 4'd1);
    v0 = valid_count;
    key_down[0*4+2] = 1'b1;
    clocks(60);
    check("1+3 code", 32'(keyPressed), 32'd1);
    check("1+3 no strobe", 32'(valid_count - v0), 32'd0);
    key_down[0*4+0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (valid_count != v0) got = 1'b1;
    end
    check("key 3 after 1 accepted", 32'(got), 32'd1);
    check("key 3 after 1 code", 32'(keyPressed), 32'd3);
    release_wait("key 3", 4'd3);

    // ---------------- same-column overlap: 1 and 4 ----------------
    v0 = valid_count;
    key_down[0*4+0] = 1'b1;
    key_down[1*4+0] = 1'b1;
    clocks(100);
    check("1+4 no strobe", 32'(valid_count - v0), 32'd0);
    check("1+4 trig", 32'(trig), 32'd0);
    key_down = 16'h0000;
    clocks(8);

    // ---------------- ClearAll during HELD of key 9 ----------------
    press_accept("key 9", 2, 2, 4'd9);
    v0 = valid_count;
    @(posedge clock);
    #3 ClearAll = 1'b0;
    #1;
    check("9 clr trig", 32'(trig), 32'd0);
    check("9 clr keyPressed", 32'(keyPressed), 32'd0);
    @(negedge clock);
    ClearAll = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (valid_count != v0) got = 1'b1;
    end
    check("9 reaccepted", 32'(got), 32'd1);
    check("9 reaccepted code", 32'(keyPressed), 32'd9);
    check("9 reaccepted trig", 32'(trig), 32'd1);
    release_wait("key 9", 4'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
